ppu_hazard_sequencer: RTL and testbench
=======================================

// Module: ppu_hazard_sequencer
// PURPOSE
//  Pipeline sequencer for the PPU 5-stage datapath. Sits beside the control unit and tracks
//  destination/RF-write/load info for the EX, MEM and WB stages in shadow registers. Drives
//  PC/NPC/IF-ID enables, NOP injection into ID/EX, the IF squash after a taken branch or jump
//  (delay slot kept), and the ALU operand forwarding selects.
// PARAMETERS
//  REG_W     5  register-specifier width
//  FILL_CYC  1  cycles held in S_FILL after reset before normal issue
// PORTS
//  clk          in   1      system clock; only clock
//  reset        in   1      synchronous, active-high reset
//  id_rs        in   REG_W  rs field of instruction in ID
//  id_rt        in   REG_W  rt field of instruction in ID
//  id_uses_rs   in   1      ID instruction reads rs
//  id_uses_rt   in   1      ID instruction reads rt (register operand or store data)
//  id_dest      in   REG_W  destination after rd/rt/r31 select
//  id_rf_en     in   1      control-word RF enable (bit 9)
//  id_load      in   1      control-word load flag (bit 10), set only for memory loads
//  ex_taken     in   1      branch condition true, or unconditional jump, resolved in EX
//  pc_en        out  1      PC load enable
//  npc_en       out  1      nPC load enable
//  if_id_en     out  1      IF/ID register load enable
//  if_flush     out  1      IF/ID loads NOP instead of fetched word
//  nop_sel      out  1      1 = control word into ID/EX forced to 22'b0
//  fwd_a        out  2      rs operand: 00 RF, 01 EX result, 10 MEM result, 11 WB result
//  fwd_b        out  2      rt operand, same encoding as fwd_a
// BEHAVIOUR
//  Reset, checked on each clk edge while reset=1:
//   - FSM goes to S_FILL; shadow EX/MEM/WB entries cleared (dest=0, rf_en=0, load=0).
//   - Outputs while reset is high: pc_en=npc_en=if_id_en=0, if_flush=1, nop_sel=1, fwd_a=fwd_b=00.
//   - Reset asserted mid-stall or mid-flush overrides everything on the next edge.
//  S_FILL: if_flush=1, nop_sel=1, pc_en=npc_en=1, if_id_en=1; counter runs FILL_CYC cycles,
//   then S_RUN.
//  S_RUN: all enables 1 and nop_sel=0, except:
//   - load-use hazard: EX.load & EX.rf_en & EX.dest!=0 & ((id_uses_rs & id_rs==EX.dest) |
//     (id_uses_rt & id_rt==EX.dest)).
//   - On a load-use hazard: pc_en=npc_en=if_id_en=0 and nop_sel=1 (combinational, same cycle).
//     FSM goes to S_STALL.
//  S_STALL: exactly one cycle with all enables 1 and nop_sel=0, then S_RUN. The ID instruction
//   now forwards from MEM, so a stall is never longer than 1 cycle.
//  Taken branch or jump (ex_taken=1 in S_RUN): if_flush=1 for that cycle and enables stay 1.
//   - The delay-slot instruction in ID proceeds; the fetched word is squashed.
//  A load can never be in EX together with a taken branch, so ex_taken and a load-use hazard
//   are mutually exclusive. If both are seen, ex_taken wins (flush, no stall) and the bench
//   flags it as an error.
//  Shadow pipeline update each edge (not in reset):
//   - WB<=MEM and MEM<=EX.
//   - EX<={id_dest,id_rf_en,id_load}, or all-zero when nop_sel=1.
//  Forwarding (combinational from shadow registers, all states):
//   - Priority is EX > MEM > WB.
//   - A match needs the stage's rf_en=1, dest!=0 and dest==id_rs (or id_rt).
//   - EX-stage loads are never forwarded (the stall covers them).
//   - No match gives 00. Register 0 always gives 00.
// STRUCTURE
//  ppu_pipe_pkg: FSM state encodings (S_FILL/S_RUN/S_STALL), FWD_* select constants, control
//   word width (22) and bit indices for RF_EN/LOAD.
//  Sub-module ppu_fwd_select, instantiated twice (A and B): inputs are src, uses flag and the
//   three shadow entries; output is the 2-bit select.
// TESTING
//  1 reset 3 cycles, release -> FILL_CYC cycles with if_flush=1, nop_sel=1; then all enables 1
//    and fwd 00.
//  2 EX: lbu dest=5; ID: subu rs=5 -> pc_en=if_id_en=0, nop_sel=1 for 1 cycle; next cycle
//    fwd_a=10.
//  3 EX: addiu dest=7; MEM: addiu dest=7; ID: rs=7 -> fwd_a=01 (EX wins). Same with rt=7
//    -> fwd_b=01.
//  4 ex_taken=1 in S_RUN -> if_flush=1 for one cycle only; pc_en=1; the delay-slot instruction
//    in ID is not bubbled.
//  5 dest=0 with rf_en=1 in EX/MEM/WB, ID rs=rt=0 -> fwd_a=fwd_b=00 and no stall.
//  6 reset asserted during S_STALL -> next edge in S_FILL with shadows cleared; ex_taken plus
//    hazard -> flush, no stall.

Source files
------------

// File: rtl/ppu_pipe_pkg.sv
// Shared encodings for the PPU pipeline sequencer: FSM states, forwarding
// selects and the control-word layout the sequencer zeroes on a bubble.
package ppu_pipe_pkg;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2
   } seq_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   localparam int CTRL_W      = 22;
   localparam int CTRL_RF_EN  = 9;
   localparam int CTRL_LOAD   = 10;

endpackage

// File: rtl/ppu_fwd_select.sv
// Operand forwarding select for one ALU source. Youngest producer wins
// (EX > MEM > WB); an EX-stage load has no result yet and is skipped, the
// load-use stall covers that case. Register 0 never forwards.
module ppu_fwd_select
   import ppu_pipe_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] i_src,
   input  logic             i_uses,
   input  logic [REG_W-1:0] i_ex_dest,
   input  logic             i_ex_rf_en,
   input  logic             i_ex_load,
   input  logic [REG_W-1:0] i_mem_dest,
   input  logic             i_mem_rf_en,
   input  logic [REG_W-1:0] i_wb_dest,
   input  logic             i_wb_rf_en,
   output logic [1:0]       o_sel
);

   // Priority match against the shadow entries; src!=0 also excludes dest 0.
   always_comb begin
      o_sel = FWD_RF;
      if (i_uses && (i_src != '0)) begin
         if (i_ex_rf_en && !i_ex_load && (i_ex_dest == i_src))
            o_sel = FWD_EX;
         else if (i_mem_rf_en && (i_mem_dest == i_src))
            o_sel = FWD_MEM;
         else if (i_wb_rf_en && (i_wb_dest == i_src))
            o_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/ppu_hazard_sequencer.sv
// Pipeline sequencer for the PPU 5-stage datapath. Shadows dest/rf_en/load
// for EX, MEM and WB, detects load-use hazards (one-cycle stall), squashes
// the fetched word after a taken branch/jump (delay slot kept) and drives
// the ALU forwarding selects.
module ppu_hazard_sequencer
   import ppu_pipe_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int FILL_CYC = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_rf_en,
   input  logic             id_load,
   input  logic             ex_taken,
   output logic             pc_en,
   output logic             npc_en,
   output logic             if_id_en,
   output logic             if_flush,
   output logic             nop_sel,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   localparam int CNT_W = (FILL_CYC > 1) ? $clog2(FILL_CYC) : 1;
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYC - 1);

   seq_state_e       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_fill_cnt;

   logic [REG_W-1:0] r_ex_dest, r_mem_dest, r_wb_dest;
   logic             r_ex_rf_en, r_mem_rf_en, r_wb_rf_en;
   logic             r_ex_load;
   logic             w_hazard;
   logic [1:0]       w_fwd_a, w_fwd_b;

   // Load in EX whose destination is read by the instruction in ID.
   assign w_hazard = r_ex_load && r_ex_rf_en && (r_ex_dest != '0) &&
                     ((id_uses_rs && (id_rs == r_ex_dest)) ||
                      (id_uses_rt && (id_rt == r_ex_dest)));

   // State register and fill counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_FILL;
         r_fill_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_FILL && r_fill_cnt != FILL_LAST)
            r_fill_cnt <= r_fill_cnt + 1'b1;
         else
            r_fill_cnt <= '0;
      end
   end

   // Next state and pipeline controls; ex_taken outranks a (illegal) hazard.
   always_comb begin
      w_state_nxt = r_state;
      pc_en       = 1'b0;
      npc_en      = 1'b0;
      if_id_en    = 1'b0;
      if_flush    = 1'b1;
      nop_sel     = 1'b1;
      if (!reset) begin
         case (r_state)
            S_FILL: begin
               pc_en    = 1'b1;
               npc_en   = 1'b1;
               if_id_en = 1'b1;
               if (r_fill_cnt == FILL_LAST)
                  w_state_nxt = S_RUN;
            end
            S_RUN: begin
               pc_en    = 1'b1;
               npc_en   = 1'b1;
               if_id_en = 1'b1;
               if_flush = 1'b0;
               nop_sel  = 1'b0;
               if (ex_taken) begin
                  if_flush = 1'b1;
               end else if (w_hazard) begin
                  pc_en       = 1'b0;
                  npc_en      = 1'b0;
                  if_id_en    = 1'b0;
                  nop_sel     = 1'b1;
                  w_state_nxt = S_STALL;
               end
            end
            S_STALL: begin
               pc_en       = 1'b1;
               npc_en      = 1'b1;
               if_id_en    = 1'b1;
               if_flush    = 1'b0;
               nop_sel     = 1'b0;
               w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_FILL;
         endcase
      end
   end

   // Shadow pipeline: advance every edge, bubble into EX when nop_sel is set.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_dest   <= '0;
         r_ex_rf_en  <= 1'b0;
         r_ex_load   <= 1'b0;
         r_mem_dest  <= '0;
         r_mem_rf_en <= 1'b0;
         r_wb_dest   <= '0;
         r_wb_rf_en  <= 1'b0;
      end else begin
         r_wb_dest   <= r_mem_dest;
         r_wb_rf_en  <= r_mem_rf_en;
         r_mem_dest  <= r_ex_dest;
         r_mem_rf_en <= r_ex_rf_en;
         if (nop_sel) begin
            r_ex_dest  <= '0;
            r_ex_rf_en <= 1'b0;
            r_ex_load  <= 1'b0;
         end else begin
            r_ex_dest  <= id_dest;
            r_ex_rf_en <= id_rf_en;
            r_ex_load  <= id_load;
         end
      end
   end

   ppu_fwd_select #(.REG_W(REG_W)) u_fwd_a (
      .i_src       (id_rs),
      .i_uses      (id_uses_rs),
      .i_ex_dest   (r_ex_dest),
      .i_ex_rf_en  (r_ex_rf_en),
      .i_ex_load   (r_ex_load),
      .i_mem_dest  (r_mem_dest),
      .i_mem_rf_en (r_mem_rf_en),
      .i_wb_dest   (r_wb_dest),
      .i_wb_rf_en  (r_wb_rf_en),
      .o_sel       (w_fwd_a)
   );

   ppu_fwd_select #(.REG_W(REG_W)) u_fwd_b (
      .i_src       (id_rt),
      .i_uses      (id_uses_rt),
      .i_ex_dest   (r_ex_dest),
      .i_ex_rf_en  (r_ex_rf_en),
      .i_ex_load   (r_ex_load),
      .i_mem_dest  (r_mem_dest),
      .i_mem_rf_en (r_mem_rf_en),
      .i_wb_dest   (r_wb_dest),
      .i_wb_rf_en  (r_wb_rf_en),
      .o_sel       (w_fwd_b)
   );

   // Selects read RF while reset is held.
   assign fwd_a = reset ? FWD_RF : w_fwd_a;
   assign fwd_b = reset ? FWD_RF : w_fwd_b;

endmodule

// File: tb/tb_ppu_hazard_sequencer.sv
// Bench for ppu_hazard_sequencer: directed scenarios plus a randomized run,
// all compared against a behavioural pipeline model kept here.
module tb_ppu_hazard_sequencer;

   localparam int REG_W    = 5;
   localparam int FILL_CYC = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [REG_W-1:0] id_rs, id_rt, id_dest;
   logic             id_uses_rs, id_uses_rt, id_rf_en, id_load, ex_taken;
   logic             pc_en, npc_en, if_id_en, if_flush, nop_sel;
   logic [1:0]       fwd_a, fwd_b;
   logic [8:0]       obs;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model: stage 0 = EX, 1 = MEM, 2 = WB.
   logic [REG_W-1:0] m_dest [3];
   bit               m_rf   [3];
   bit               m_ld   [3];
   int               m_fill_left;
   bit               m_stalled;

   always #5 clk = ~clk;

   assign obs = {pc_en, npc_en, if_id_en, if_flush, nop_sel, fwd_a, fwd_b};

   ppu_hazard_sequencer #(.REG_W(REG_W), .FILL_CYC(FILL_CYC)) dut (
      .clk        (clk),
      .reset      (reset),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .id_dest    (id_dest),
      .id_rf_en   (id_rf_en),
      .id_load    (id_load),
      .ex_taken   (ex_taken),
      .pc_en      (pc_en),
      .npc_en     (npc_en),
      .if_id_en   (if_id_en),
      .if_flush   (if_flush),
      .nop_sel    (nop_sel),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b)
   );

   function automatic void m_clear();
      for (int s = 0; s < 3; s++) begin
         m_dest[s] = '0;
         m_rf[s]   = 1'b0;
         m_ld[s]   = 1'b0;
      end
      m_fill_left = FILL_CYC;
      m_stalled   = 1'b0;
   endfunction

   function automatic bit m_hazard();
      return m_ld[0] && m_rf[0] && (m_dest[0] != 0) &&
             ((id_uses_rs && id_rs == m_dest[0]) || (id_uses_rt && id_rt == m_dest[0]));
   endfunction

   function automatic logic [1:0] m_fwd(input logic [REG_W-1:0] src, input bit uses);
      if (!uses || src == 0) return 2'd0;
      for (int s = 0; s < 3; s++)
         if (m_rf[s] && m_dest[s] == src && !(s == 0 && m_ld[0]))
            return 2'(s + 1);
      return 2'd0;
   endfunction

   function automatic logic [8:0] exp_out();
      bit run, tk, hz;
      if (reset) return 9'b000_1_1_00_00;
      if (m_fill_left > 0)
         return {5'b111_1_1, m_fwd(id_rs, id_uses_rs), m_fwd(id_rt, id_uses_rt)};
      run = !m_stalled;
      tk  = run && ex_taken;
      hz  = run && m_hazard() && !tk;
      return {hz ? 3'b000 : 3'b111, tk, hz, m_fwd(id_rs, id_uses_rs), m_fwd(id_rt, id_uses_rt)};
   endfunction

   // Advance one clock and move the model along with it.
   task automatic tick();
      bit run, tk, hz, nop;
      @(posedge clk);
      if (reset) begin
         m_clear();
      end else begin
         run = (m_fill_left == 0) && !m_stalled;
         tk  = run && ex_taken;
         hz  = run && m_hazard() && !tk;
         nop = (m_fill_left > 0) || hz;
         m_stalled = hz;
         if (m_fill_left > 0) m_fill_left--;
         m_dest[2] = m_dest[1]; m_rf[2] = m_rf[1]; m_ld[2] = m_ld[1];
         m_dest[1] = m_dest[0]; m_rf[1] = m_rf[0]; m_ld[1] = m_ld[0];
         m_dest[0] = nop ? '0 : id_dest;
         m_rf[0]   = nop ? 1'b0 : id_rf_en;
         m_ld[0]   = nop ? 1'b0 : id_load;
      end
      #1;
   endtask

   task automatic set_id(input int dest, input bit rf, input bit ld,
                         input int rs, input bit urs, input int rt, input bit urt);
      id_dest = REG_W'(dest); id_rf_en = rf; id_load = ld;
      id_rs = REG_W'(rs); id_uses_rs = urs; id_rt = REG_W'(rt); id_uses_rt = urt;
   endtask

   task automatic idle(input int n);
      set_id(0, 0, 0, 0, 0, 0, 0);
      ex_taken = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ex_taken = 1'b0;
      set_id(3, 1, 1, 3, 1, 3, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== 9'b000_1_1_00_00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want %b", obs, 9'b000110000);
         end
         tick();
      end
      reset = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < FILL_CYC; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== 9'b111_1_1_00_00 || obs !== exp_out()) begin
            tests_failed++;
            $display("FAIL fill_phase: got %b want %b", obs, 9'b111110000);
         end
         tick();
      end
      @(negedge clk);
      tests_run++;
      if (obs !== 9'b111_0_0_00_00) begin
         tests_failed++;
         $display("FAIL first_run: got %b want %b", obs, 9'b111000000);
      end
      tick();
   endtask

   task automatic test_load_use();
      idle(3);
      set_id(5, 1, 1, 2, 1, 0, 0);        // lbu r5
      tick();
      set_id(8, 1, 0, 5, 1, 6, 1);        // subu r8, r5, r6
      @(negedge clk);
      tests_run++;
      if ({pc_en, npc_en, if_id_en, nop_sel} !== 4'b0001 || obs !== exp_out()) begin
         tests_failed++;
         $display("FAIL load_use_stall: got %b want %b", obs, exp_out());
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (fwd_a !== 2'b10 || {pc_en, if_id_en, nop_sel} !== 3'b110 || obs !== exp_out()) begin
         tests_failed++;
         $display("FAIL load_use_fwd_mem: got %b want fwd_a=10 (%b)", obs, exp_out());
      end
      tick();
   endtask

   task automatic test_ex_priority();
      idle(3);
      set_id(7, 1, 0, 0, 0, 0, 0);        // addiu r7
      tick();
      tick();                             // second addiu r7
      set_id(0, 0, 0, 7, 1, 7, 1);
      @(negedge clk);
      tests_run++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b01 || obs !== exp_out()) begin
         tests_failed++;
         $display("FAIL ex_over_mem: got %b want fwd_a=01 fwd_b=01", obs);
      end
      tick();
   endtask

   task automatic test_branch();
      idle(2);
      set_id(9, 1, 0, 0, 0, 0, 0);        // delay-slot instruction writes r9
      ex_taken = 1'b1;
      @(negedge clk);
      tests_run++;
      if (obs[8:4] !== 5'b111_1_0) begin
         tests_failed++;
         $display("FAIL taken_flush: got %b want 11110", obs[8:4]);
      end
      tick();
      ex_taken = 1'b0;
      set_id(0, 0, 0, 9, 1, 0, 0);
      @(negedge clk);
      tests_run++;
      if (obs[8:4] !== 5'b111_0_0 || fwd_a !== 2'b01) begin
         tests_failed++;
         $display("FAIL taken_one_cycle: got %b want 11100 fwd_a=01", obs);
      end
      tick();
   endtask

   task automatic test_reg0();
      idle(3);
      set_id(0, 1, 1, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== 9'b111_0_0_00_00) begin
            tests_failed++;
            $display("FAIL reg0_no_fwd: got %b want %b", obs, 9'b111000000);
         end
         tick();
      end
   endtask

   task automatic test_reset_in_stall();
      idle(2);
      set_id(5, 1, 1, 0, 0, 0, 0);
      tick();
      set_id(4, 1, 0, 5, 1, 0, 0);
      @(negedge clk);
      tests_run++;
      if (nop_sel !== 1'b1 || pc_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_before_reset: got %b want pc_en=0 nop_sel=1", obs);
      end
      tick();
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if (obs !== 9'b000_1_1_00_00) begin
         tests_failed++;
         $display("FAIL reset_in_stall: got %b want %b", obs, 9'b000110000);
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < FILL_CYC; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== exp_out() || if_flush !== 1'b1 || fwd_a !== 2'b00) begin
            tests_failed++;
            $display("FAIL refill_after_reset: got %b want %b", obs, exp_out());
         end
         tick();
      end
      set_id(0, 0, 0, 5, 1, 5, 1);
      @(negedge clk);
      tests_run++;
      if (obs !== 9'b111_0_0_00_00) begin
         tests_failed++;
         $display("FAIL shadows_cleared: got %b want %b", obs, 9'b111000000);
      end
      tick();
   endtask

   task automatic test_taken_hazard();
      idle(2);
      set_id(5, 1, 1, 0, 0, 0, 0);
      tick();
      set_id(6, 1, 0, 5, 1, 0, 0);
      ex_taken = 1'b1;
      $display("[TB] note: driving ex_taken together with a load-use hazard (illegal pairing)");
      @(negedge clk);
      tests_run++;
      if (obs[8:4] !== 5'b111_1_0) begin
         tests_failed++;
         $display("FAIL taken_beats_hazard: got %b want 11110", obs[8:4]);
      end
      tick();
      ex_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      tests_run++;
      if (obs[8:4] !== 5'b111_0_0) begin
         tests_failed++;
         $display("FAIL no_stall_after_taken: got %b want 11100", obs[8:4]);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         bit rf;
         reset = ($urandom_range(0, 79) == 0);
         rf = $urandom_range(0, 3) != 0;
         set_id($urandom_range(0, 7), rf, rf && ($urandom_range(0, 2) == 0),
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1));
         ex_taken = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         tests_run++;
         if (obs !== exp_out()) begin
            tests_failed++;
            $display("FAIL random_cycle_%0d: got %b want %b", i, obs, exp_out());
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      m_clear();
      reset = 1'b1;
      ex_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_load_use();
      test_ex_priority();
      test_branch();
      test_reg0();
      test_reset_in_stall();
      test_taken_hazard();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
